// File: rtl/dc_huffman_encoder_pkg.sv
// Shared JPEG Huffman definitions: luminance DC code table, field widths and
// the encoder FSM state encoding.
package jpeg_huff_pkg;

    localparam int CAT_W        = 4;
    localparam int MAX_CODE_LEN = 9;
    localparam int MAX_AMP_LEN  = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_CODE = 2'd2,
        ST_AMP  = 2'd3
    } huff_state_e;

    // Luminance DC code, right-aligned in MAX_CODE_LEN bits
    function automatic logic [MAX_CODE_LEN-1:0] dc_lum_code(input logic [CAT_W-1:0] cat);
        case (cat)
            4'd0:    return 9'b000000000;
            4'd1:    return 9'b000000010;
            4'd2:    return 9'b000000011;
            4'd3:    return 9'b000000100;
            4'd4:    return 9'b000000101;
            4'd5:    return 9'b000000110;
            4'd6:    return 9'b000001110;
            4'd7:    return 9'b000011110;
            4'd8:    return 9'b000111110;
            4'd9:    return 9'b001111110;
            4'd10:   return 9'b011111110;
            4'd11:   return 9'b111111110;
            default: return 9'b000000000;
        endcase
    endfunction

    function automatic logic [CAT_W-1:0] dc_lum_len(input logic [CAT_W-1:0] cat);
        case (cat)
            4'd0:    return 4'd2;
            4'd1:    return 4'd3;
            4'd2:    return 4'd3;
            4'd3:    return 4'd3;
            4'd4:    return 4'd3;
            4'd5:    return 4'd3;
            4'd6:    return 4'd4;
            4'd7:    return 4'd5;
            4'd8:    return 4'd6;
            4'd9:    return 4'd7;
            4'd10:   return 4'd8;
            4'd11:   return 4'd9;
            default: return 4'd2;
        endcase
    endfunction

endpackage

// File: rtl/dc_huffman_encoder_if.sv
// Coefficient input and serialized bit output of the DC Huffman encoder.
interface dc_huffman_encoder_if #(parameter int DC_W = 11);

    logic signed [DC_W-1:0] dc_in;
    logic                   in_valid;
    logic                   in_ready;
    logic                   restart;
    logic                   bit_out;
    logic                   bit_valid;
    logic                   bit_ready;
    logic                   bit_last;

    modport master (
        output dc_in, in_valid, restart, bit_ready,
        input  in_ready, bit_out, bit_valid, bit_last
    );

    modport slave (
        input  dc_in, in_valid, restart, bit_ready,
        output in_ready, bit_out, bit_valid, bit_last
    );

endinterface

// File: rtl/dc_category_encoder.sv
// Maps a signed difference to its JPEG size category and amplitude bits
// (right-aligned, one's complement for negative values).
module dc_category_encoder
    import jpeg_huff_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0]     diff,
    output logic [CAT_W-1:0] cat,
    output logic [W-2:0]     amp
);

    localparam logic [W-1:0] ONE_FULL = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-2:0] ONE_AMP  = {{(W-2){1'b0}}, 1'b1};

    logic [W-1:0]     mag_s;
    logic [W-2:0]     dm1_s;
    logic [W-2:0]     mask_s;
    logic [CAT_W-1:0] cat_s;

    assign mag_s  = diff[W-1] ? (~diff + ONE_FULL) : diff;
    // Only the low bits of diff-1 are ever emitted, so the borrow out is irrelevant
    assign dm1_s  = diff[W-2:0] - ONE_AMP;
    assign mask_s = ~({(W-1){1'b1}} << cat_s);

    // Category is the position of the highest set magnitude bit
    always_comb begin
        cat_s = {CAT_W{1'b0}};
        for (int i = 0; i < W; i++) begin
            cat_s = mag_s[i] ? CAT_W'(i + 1) : cat_s;
        end
    end

    assign cat = cat_s;
    assign amp = (diff[W-1] ? dm1_s : diff[W-2:0]) & mask_s;

endmodule

// File: rtl/dc_huffman_encoder.sv
// DPCM DC coefficient encoder: difference against the previous DC, luminance
// DC Huffman code plus amplitude, serialized MSB-first over valid/ready.
module dc_huffman_encoder
    import jpeg_huff_pkg::*;
#(
    parameter int DC_W = 11
) (
    input logic                clk,
    input logic                rst,
    dc_huffman_encoder_if.slave bus
);

    huff_state_e              state_r;
    huff_state_e              state_nx_s;

    logic [DC_W-1:0]          dc_r;
    logic [DC_W-1:0]          pred_r;
    logic [DC_W:0]            diff_s;
    logic [CAT_W-1:0]         cat_s;
    logic [DC_W-1:0]          amp_s;
    logic [DC_W-1:0]          amp_al_s;
    logic [MAX_CODE_LEN-1:0]  code_s;
    logic [MAX_CODE_LEN-1:0]  code_al_s;
    logic [CAT_W-1:0]         code_len_s;

    logic [CAT_W-1:0]         cat_r;
    logic [MAX_CODE_LEN-1:0]  code_sh_r;
    logic [CAT_W-1:0]         code_cnt_r;
    logic [DC_W-1:0]          amp_sh_r;
    logic [CAT_W-1:0]         amp_cnt_r;
    logic                     bit_out_r;
    logic                     bit_valid_r;
    logic                     bit_last_r;
    logic                     in_ready_r;
    logic                     bit_acc_s;

    assign diff_s = {dc_r[DC_W-1], dc_r} - {pred_r[DC_W-1], pred_r};

    dc_category_encoder #(.W(DC_W + 1)) u_cat (
        .diff (diff_s),
        .cat  (cat_s),
        .amp  (amp_s)
    );

    // Left-align code and amplitude so both shift out of the MSB
    assign code_s     = dc_lum_code(cat_s);
    assign code_len_s = dc_lum_len(cat_s);
    assign code_al_s  = code_s << (CAT_W'(MAX_CODE_LEN) - code_len_s);
    assign amp_al_s   = amp_s << (CAT_W'(DC_W) - cat_s);

    assign bit_acc_s  = bit_valid_r && bus.bit_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode; counters hold the bits remaining after the one shown
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) state_nx_s = ST_CALC;
                else              state_nx_s = ST_IDLE;
            end
            ST_CALC: state_nx_s = ST_CODE;
            ST_CODE: begin
                if (bit_acc_s && (code_cnt_r == 4'd0)) begin
                    if (cat_r == 4'd0) state_nx_s = ST_IDLE;
                    else               state_nx_s = ST_AMP;
                end else begin
                    state_nx_s = ST_CODE;
                end
            end
            ST_AMP: begin
                if (bit_acc_s && (amp_cnt_r == 4'd0)) state_nx_s = ST_IDLE;
                else                                   state_nx_s = ST_AMP;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // DC predictor; a restart overrides the CALC-cycle update
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_r <= '0;
        end else if (bus.restart) begin
            pred_r <= '0;
        end else if (state_r == ST_CALC) begin
            pred_r <= dc_r;
        end
    end

    // Datapath: coefficient capture, shift registers and registered bit outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_r        <= '0;
            cat_r       <= 4'd0;
            code_sh_r   <= '0;
            code_cnt_r  <= 4'd0;
            amp_sh_r    <= '0;
            amp_cnt_r   <= 4'd0;
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            bit_last_r  <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            in_ready_r <= (state_nx_s == ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) dc_r <= bus.dc_in;
                end
                ST_CALC: begin
                    cat_r       <= cat_s;
                    bit_out_r   <= code_al_s[MAX_CODE_LEN-1];
                    bit_valid_r <= 1'b1;
                    bit_last_r  <= 1'b0;
                    code_sh_r   <= code_al_s << 1;
                    code_cnt_r  <= code_len_s - 4'd1;
                    amp_sh_r    <= amp_al_s;
                    amp_cnt_r   <= 4'd0;
                end
                ST_CODE: begin
                    if (bit_acc_s) begin
                        if (code_cnt_r != 4'd0) begin
                            bit_out_r  <= code_sh_r[MAX_CODE_LEN-1];
                            code_sh_r  <= code_sh_r << 1;
                            code_cnt_r <= code_cnt_r - 4'd1;
                            bit_last_r <= (code_cnt_r == 4'd1) && (cat_r == 4'd0);
                        end else if (cat_r == 4'd0) begin
                            bit_out_r   <= 1'b0;
                            bit_valid_r <= 1'b0;
                            bit_last_r  <= 1'b0;
                        end else begin
                            bit_out_r  <= amp_sh_r[DC_W-1];
                            amp_sh_r   <= amp_sh_r << 1;
                            amp_cnt_r  <= cat_r - 4'd1;
                            bit_last_r <= (cat_r == 4'd1);
                        end
                    end
                end
                ST_AMP: begin
                    if (bit_acc_s) begin
                        if (amp_cnt_r != 4'd0) begin
                            bit_out_r  <= amp_sh_r[DC_W-1];
                            amp_sh_r   <= amp_sh_r << 1;
                            amp_cnt_r  <= amp_cnt_r - 4'd1;
                            bit_last_r <= (amp_cnt_r == 4'd1);
                        end else begin
                            bit_out_r   <= 1'b0;
                            bit_valid_r <= 1'b0;
                            bit_last_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    bit_valid_r <= 1'b0;
                    bit_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.bit_out   = bit_out_r;
    assign bus.bit_valid = bit_valid_r;
    assign bus.bit_last  = bit_last_r;

endmodule

// File: tb/tb_dc_huffman_encoder.sv
// Scoreboard bench for dc_huffman_encoder: directed coefficients push their
// hand-derived bit sequences; a negedge monitor pops and compares accepted bits.
module tb_dc_huffman_encoder;

    localparam int DC_W = 11;

    logic clk;
    logic rst;

    dc_huffman_encoder_if #(.DC_W(DC_W)) bus ();

    dc_huffman_encoder #(.DC_W(DC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bits given MSB-first in the low n bits; last flag on the final one
    task automatic push(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            exp_q.push_back({bits[i], (i == 0)});
        end
    endtask

    // Monitor: every accepted bit is compared with the scoreboard head
    always @(negedge clk) begin
        if (!rst && bus.bit_valid === 1'b1 && bus.bit_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bit", {31'd0, bus.bit_out}, 32'hFFFF_FFFF);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                check("bit_and_last", {30'd0, bus.bit_out, bus.bit_last}, {30'd0, e});
            end
        end
    end

    task automatic send(input int v, input logic rs_acc, input logic rs_calc);
        int cyc;
        cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 100) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        bus.dc_in    = DC_W'(v);
        bus.in_valid = 1'b1;
        bus.restart  = rs_acc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.restart  = rs_calc;
        if (rs_calc) begin
            @(posedge clk); #1;
            bus.restart = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || bus.in_ready !== 1'b1) && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 400) check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(posedge clk); #1;
        bus.restart = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.dc_in     = '0;
        bus.in_valid  = 1'b0;
        bus.restart   = 1'b0;
        bus.bit_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_bit_valid", {31'd0, bus.bit_valid}, 32'd0);
        check("rst_bit_out",   {31'd0, bus.bit_out},   32'd0);
        check("rst_bit_last",  {31'd0, bus.bit_last},  32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(posedge clk); #1;

        // dc 0: latency of first bit and return of in_ready
        push(32'b00, 2);
        send(0, 1'b0, 1'b0);
        check("calc_no_valid",   {31'd0, bus.bit_valid}, 32'd0);
        check("calc_not_ready",  {31'd0, bus.in_ready},  32'd0);
        @(posedge clk); #1;
        check("first_bit_valid", {31'd0, bus.bit_valid}, 32'd1);
        @(posedge clk); #1;
        check("busy_not_ready",  {31'd0, bus.in_ready},  32'd0);
        @(posedge clk); #1;
        check("ready_at_t4",     {31'd0, bus.in_ready},  32'd1);
        check("idle_no_valid",   {31'd0, bus.bit_valid}, 32'd0);
        wait_idle();

        // 5 then 2 (diff -3)
        push(32'b100101, 6);
        send(5, 1'b0, 1'b0);
        push(32'b01100, 5);
        send(2, 1'b0, 1'b0);
        wait_idle();

        // Extremes after restart: 1023 then -1024 (diff -2047)
        pulse_restart();
        push(32'b111111101111111111, 18);
        send(1023, 1'b0, 1'b0);
        push(32'b11111111000000000000, 20);
        send(-1024, 1'b0, 1'b0);
        wait_idle();

        // Backpressure on the second code bit of dc 5
        pulse_restart();
        push(32'b100101, 6);
        send(5, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.bit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_bit_out",   {31'd0, bus.bit_out},   32'd0);
            check("bp_bit_valid", {31'd0, bus.bit_valid}, 32'd1);
            check("bp_bit_last",  {31'd0, bus.bit_last},  32'd0);
        end
        bus.bit_ready = 1'b1;
        wait_idle();

        // Predictor 5 -> 100 (diff 95), then restart on acceptance (diff 100)
        push(32'b111101011111, 12);
        send(100, 1'b0, 1'b0);
        push(32'b111101100100, 12);
        send(100, 1'b1, 1'b0);
        wait_idle();

        // Restart during CALC beats the predictor update: 7 (diff -93), then 0 -> 00
        push(32'b111100100010, 12);
        send(7, 1'b0, 1'b1);
        push(32'b00, 2);
        send(0, 1'b0, 1'b0);
        wait_idle();

        // Reset while the third bit of an 18-bit coefficient is pending
        push(32'b111111101111111111, 18);
        send(1023, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_bit_valid", {31'd0, bus.bit_valid}, 32'd0);
        check("abort_bit_last",  {31'd0, bus.bit_last},  32'd0);
        check("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("abort_consumed",  exp_q.size(),           32'd16);
        rst = 1'b0;
        exp_q.delete();
        push(32'b00, 2);
        send(0, 1'b0, 1'b0);
        wait_idle();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
